// File: rtl/sic4_multicycle_controller_if.sv
// rtl/sic4_multicycle_controller_if.sv - instruction/data memory handshake bundle for the SIC-4 sequencer
interface sic4_multicycle_controller_if;
  logic imem_req;
  logic imem_ready;
  logic dmem_req;
  logic dmem_ready;
  logic memRead;
  logic memWrite;

  // Controller side: issues requests, receives ready
  modport master (
    output imem_req,
    output dmem_req,
    output memRead,
    output memWrite,
    input  imem_ready,
    input  dmem_ready
  );

  // Memory side: answers requests with ready
  modport slave (
    input  imem_req,
    input  dmem_req,
    input  memRead,
    input  memWrite,
    output imem_ready,
    output dmem_ready
  );
endinterface

// File: rtl/sic4_multicycle_controller.sv
// rtl/sic4_multicycle_controller.sv - multicycle FETCH/DECODE/EXEC/MEM/WB sequencer for the SIC-4 core
module sic4_multicycle_controller #(
  parameter int MAX_WAIT = 8,
  parameter int CNT_W    = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         run,
  input  logic [1:0]                   op,
  input  logic [1:0]                   funct,
  sic4_multicycle_controller_if.master mem_bus,
  output logic                         ir_write,
  output logic                         pc_write,
  output logic                         regWrite,
  output logic                         useImmediate,
  output logic                         useLoad,
  output logic [1:0]                   aluop,
  output logic [2:0]                   state,
  output logic [CNT_W-1:0]             retired,
  output logic                         fault
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_FAULT  = 3'd6
  } state_e;

  // Last tolerated not-ready cycle index; a miss on this count faults
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [1:0]       funct_q, funct_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             fault_q, fault_d;

  logic             is_load;
  logic             is_store;
  logic [1:0]       alu_sel;
  logic             imm_sel;

  // Opcode decode of the latched IR fields: memory ops always compute reg+imm
  always_comb begin
    is_load  = (op_q == 2'b10);
    is_store = (op_q == 2'b11);
    alu_sel  = op_q[1] ? 2'b00 : funct_q;
    imm_sel  = (op_q != 2'b00);
  end

  // Next-state, counters and per-phase strobes
  always_comb begin
    state_d          = state_q;
    op_d             = op_q;
    funct_d          = funct_q;
    wait_cnt_d       = wait_cnt_q;
    retired_d        = retired_q;
    fault_d          = fault_q;
    mem_bus.imem_req = 1'b0;
    mem_bus.dmem_req = 1'b0;
    mem_bus.memRead  = 1'b0;
    mem_bus.memWrite = 1'b0;
    ir_write         = 1'b0;
    pc_write         = 1'b0;
    regWrite         = 1'b0;
    useImmediate     = 1'b0;
    useLoad          = 1'b0;
    aluop            = 2'b00;

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_bus.imem_req = 1'b1;
        if (mem_bus.imem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d = S_FAULT;
          fault_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      S_DECODE: begin
        op_d    = op;
        funct_d = funct;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        aluop        = alu_sel;
        useImmediate = imm_sel;
        state_d      = op_q[1] ? S_MEM : S_WB;
      end
      S_MEM: begin
        mem_bus.dmem_req = 1'b1;
        mem_bus.memRead  = is_load;
        mem_bus.memWrite = is_store;
        useImmediate     = 1'b1;
        if (mem_bus.dmem_ready) begin
          if (is_load) begin
            state_d = S_WB;
          end else begin
            retired_d = retired_q + CNT_W'(1);
            state_d   = run ? S_FETCH : S_IDLE;
          end
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d = S_FAULT;
          fault_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      S_WB: begin
        regWrite     = 1'b1;
        aluop        = alu_sel;
        useImmediate = imm_sel;
        useLoad      = is_load;
        retired_d    = retired_q + CNT_W'(1);
        state_d      = run ? S_FETCH : S_IDLE;
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Every phase change starts a fresh wait window
    if (state_d != state_q) wait_cnt_d = 8'd0;
  end

  // State and counter registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      op_q       <= 2'b00;
      funct_q    <= 2'b00;
      wait_cnt_q <= 8'd0;
      retired_q  <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      funct_q    <= funct_d;
      wait_cnt_q <= wait_cnt_d;
      retired_q  <= retired_d;
      fault_q    <= fault_d;
    end
  end

  assign state   = state_q;
  assign retired = retired_q;
  assign fault   = fault_q;

endmodule

// File: tb/tb_sic4_multicycle_controller.sv
// tb/tb_sic4_multicycle_controller.sv - directed bench for the SIC-4 multicycle sequencer
module tb_sic4_multicycle_controller;
  logic       clk;
  logic       rst_n;
  logic       run;
  logic [1:0] op;
  logic [1:0] funct;
  logic       ir_write;
  logic       pc_write;
  logic       regWrite;
  logic       useImmediate;
  logic       useLoad;
  logic [1:0] aluop;
  logic [2:0] state;
  logic [3:0] retired;
  logic       fault;

  int checks;
  int errors;

  sic4_multicycle_controller_if mif ();

  sic4_multicycle_controller #(
    .MAX_WAIT(8),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .run(run),
    .op(op),
    .funct(funct),
    .mem_bus(mif.master),
    .ir_write(ir_write),
    .pc_write(pc_write),
    .regWrite(regWrite),
    .useImmediate(useImmediate),
    .useLoad(useLoad),
    .aluop(aluop),
    .state(state),
    .retired(retired),
    .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_imem_req"}, 32'(mif.imem_req), 0);
    chk({tag, "_dmem_req"}, 32'(mif.dmem_req), 0);
    chk({tag, "_memRead"},  32'(mif.memRead), 0);
    chk({tag, "_memWrite"}, 32'(mif.memWrite), 0);
    chk({tag, "_ir_write"}, 32'(ir_write), 0);
    chk({tag, "_pc_write"}, 32'(pc_write), 0);
    chk({tag, "_regWrite"}, 32'(regWrite), 0);
    chk({tag, "_useImm"},   32'(useImmediate), 0);
    chk({tag, "_useLoad"},  32'(useLoad), 0);
    chk({tag, "_aluop"},    32'(aluop), 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    run = 1'b0;
    op = 2'b00;
    funct = 2'b00;
    mif.imem_ready = 1'b0;
    mif.dmem_ready = 1'b0;
    step();
    step();
    chk("rst_state", 32'(state), 0);
    chk("rst_retired", 32'(retired), 0);
    chk("rst_fault", 32'(fault), 0);
    chk_quiet("rst");

    // R-type, zero-wait memories
    rst_n = 1'b1;
    run = 1'b1;
    mif.imem_ready = 1'b1;
    mif.dmem_ready = 1'b1;
    op = 2'b00;
    funct = 2'b10;
    #1;
    chk("t1_idle_state", 32'(state), 0);
    step();
    chk("t1_fetch_state", 32'(state), 1);
    chk("t1_fetch_imem_req", 32'(mif.imem_req), 1);
    chk("t1_fetch_ir_write", 32'(ir_write), 1);
    chk("t1_fetch_pc_write", 32'(pc_write), 1);
    chk("t1_fetch_regWrite", 32'(regWrite), 0);
    step();
    chk("t1_decode_state", 32'(state), 2);
    chk_quiet("t1_decode");
    step();
    chk("t1_exec_state", 32'(state), 3);
    chk("t1_exec_aluop", 32'(aluop), 2);
    chk("t1_exec_regWrite", 32'(regWrite), 0);
    chk("t1_exec_useImm", 32'(useImmediate), 0);
    step();
    chk("t1_wb_state", 32'(state), 5);
    chk("t1_wb_aluop", 32'(aluop), 2);
    chk("t1_wb_regWrite", 32'(regWrite), 1);
    chk("t1_wb_retired", 32'(retired), 0);
    step();
    chk("t1_next_state", 32'(state), 1);
    chk("t1_retired", 32'(retired), 1);

    // Load with three not-ready data cycles
    op = 2'b10;
    funct = 2'b11;
    mif.dmem_ready = 1'b0;
    step();
    chk("t2_decode_state", 32'(state), 2);
    step();
    chk("t2_exec_state", 32'(state), 3);
    chk("t2_exec_aluop", 32'(aluop), 0);
    chk("t2_exec_useImm", 32'(useImmediate), 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_mem_wait_state", 32'(state), 4);
      chk("t2_mem_wait_dmem_req", 32'(mif.dmem_req), 1);
      chk("t2_mem_wait_memRead", 32'(mif.memRead), 1);
      chk("t2_mem_wait_memWrite", 32'(mif.memWrite), 0);
    end
    step();
    mif.dmem_ready = 1'b1;
    #1;
    chk("t2_mem_last_state", 32'(state), 4);
    chk("t2_mem_last_memRead", 32'(mif.memRead), 1);
    chk("t2_mem_last_aluop", 32'(aluop), 0);
    step();
    op = 2'b00;
    funct = 2'b01;
    #1;
    chk("t2_wb_state", 32'(state), 5);
    chk("t2_wb_useLoad", 32'(useLoad), 1);
    chk("t2_wb_regWrite", 32'(regWrite), 1);
    chk("t2_wb_aluop_held", 32'(aluop), 0);
    chk("t2_wb_retired", 32'(retired), 1);
    step();
    chk("t2_next_state", 32'(state), 1);
    chk("t2_retired", 32'(retired), 2);

    // Store, ready immediately
    op = 2'b11;
    funct = 2'b01;
    step();
    chk("t3_decode_state", 32'(state), 2);
    step();
    chk("t3_exec_state", 32'(state), 3);
    chk("t3_exec_aluop", 32'(aluop), 0);
    chk("t3_exec_useImm", 32'(useImmediate), 1);
    chk("t3_exec_regWrite", 32'(regWrite), 0);
    step();
    chk("t3_mem_state", 32'(state), 4);
    chk("t3_mem_memWrite", 32'(mif.memWrite), 1);
    chk("t3_mem_memRead", 32'(mif.memRead), 0);
    chk("t3_mem_aluop", 32'(aluop), 0);
    chk("t3_mem_useImm", 32'(useImmediate), 1);
    chk("t3_mem_regWrite", 32'(regWrite), 0);
    chk("t3_mem_retired", 32'(retired), 2);
    step();
    chk("t3_next_state", 32'(state), 1);
    chk("t3_retired", 32'(retired), 3);

    // Instruction fetch timeout
    mif.imem_ready = 1'b0;
    #1;
    chk("t4_fetch_ir_write", 32'(ir_write), 0);
    for (int i = 0; i < 7; i++) begin
      step();
      chk("t4_fetch_wait_state", 32'(state), 1);
      chk("t4_fetch_wait_fault", 32'(fault), 0);
    end
    step();
    chk("t4_fault_state", 32'(state), 6);
    chk("t4_fault_flag", 32'(fault), 1);
    chk_quiet("t4_fault");
    mif.imem_ready = 1'b1;
    step();
    step();
    chk("t4_fault_sticky_state", 32'(state), 6);
    chk("t4_fault_sticky_flag", 32'(fault), 1);
    rst_n = 1'b0;
    step();
    chk("t4_reset_state", 32'(state), 0);
    chk("t4_reset_fault", 32'(fault), 0);
    chk("t4_reset_retired", 32'(retired), 0);

    // Sixteen R-type instructions wrap the 4-bit retire counter
    rst_n = 1'b1;
    op = 2'b00;
    funct = 2'b01;
    step();
    chk("t5_first_fetch", 32'(state), 1);
    for (int i = 1; i <= 16; i++) begin
      step();
      step();
      step();
      step();
      chk("t5_loop_state", 32'(state), 1);
      if (i == 15) chk("t5_retired_15", 32'(retired), 15);
      if (i == 16) chk("t5_retired_wrap", 32'(retired), 0);
    end
    step();
    step();
    chk("t5_exec17_state", 32'(state), 3);
    run = 1'b0;
    step();
    chk("t5_wb17_state", 32'(state), 5);
    chk("t5_wb17_regWrite", 32'(regWrite), 1);
    step();
    chk("t5_idle_state", 32'(state), 0);
    chk("t5_idle_retired", 32'(retired), 1);
    chk("t5_idle_imem_req", 32'(mif.imem_req), 0);
    step();
    chk("t5_idle_hold_state", 32'(state), 0);
    chk("t5_idle_hold_imem_req", 32'(mif.imem_req), 0);

    // Ready on the last tolerated cycle beats the timeout, then reset mid-store
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    run = 1'b1;
    op = 2'b11;
    funct = 2'b00;
    mif.imem_ready = 1'b0;
    mif.dmem_ready = 1'b0;
    step();
    chk("t6_fetch_state", 32'(state), 1);
    for (int i = 0; i < 7; i++) step();
    mif.imem_ready = 1'b1;
    #1;
    chk("t6_fetch_cycle8_state", 32'(state), 1);
    step();
    chk("t6_ready_wins_state", 32'(state), 2);
    chk("t6_ready_wins_fault", 32'(fault), 0);
    step();
    step();
    chk("t6_mem_state", 32'(state), 4);
    chk("t6_mem_memWrite", 32'(mif.memWrite), 1);
    step();
    chk("t6_mem_wait_memWrite", 32'(mif.memWrite), 1);
    rst_n = 1'b0;
    step();
    chk("t6_reset_state", 32'(state), 0);
    chk("t6_reset_memWrite", 32'(mif.memWrite), 0);
    chk("t6_reset_dmem_req", 32'(mif.dmem_req), 0);
    chk("t6_reset_retired", 32'(retired), 0);
    rst_n = 1'b1;
    run = 1'b0;
    step();
    chk("t6_after_state", 32'(state), 0);
    chk("t6_after_memWrite", 32'(mif.memWrite), 0);
    chk("t6_after_retired", 32'(retired), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
